dbus_store_buffer: RTL and testbench

DBUS_STORE_BUFFER -- requirements
Module: dbus_store_buffer

---
 rtl/dbus_store_buffer.sv | 184 ++++++++++++++++++
 tb/tb_dbus_store_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dbus_store_buffer
// Purpose  : Store buffer between the load/store unit data bus and a generic
//            memory bus. Stores are queued in a circular FIFO and drained to
//            memory in order. Loads whose bytes are fully covered by the
//            youngest buffered store to the same word are forwarded. All other
//            loads wait until the buffer has drained, then go to memory.
// Ports    : CLK, RST (sync, active-high)
//            cpu_*  : request from the LSU (addr/wdata/byte_en/ren/wen),
//                     plus rdata/busy back to it
//            mem_*  : request to memory (addr/wdata/byte_en/ren/wen),
//                     plus rdata/busy back from it
//            drained: no store buffered and none in flight
// Revision : 1.0 - initial release
// ============================================================================
module dbus_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_en,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic        drained
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_PTR_W-1:0] head_q, head_d;
    logic [c_PTR_W-1:0] tail_q, tail_d;
    logic [c_CNT_W-1:0] count_q, count_d;

    logic [31:0] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [3:0]  be_q    [DEPTH];

    logic               w_full;
    logic               w_load_req;
    logic               w_push;
    logic               w_pop;
    logic               w_fwd_match;
    logic               w_fwd_hit;
    logic [c_PTR_W-1:0] w_fwd_idx;

    assign w_full     = (count_q == c_FULL);
    assign w_load_req = cpu_ren && !cpu_wen;
    // A full buffer refuses the store even if a pop happens this cycle.
    assign w_push     = cpu_wen && !w_full;
    assign drained    = (count_q == '0) && (state_q != DRAIN);

    // Walk valid entries oldest to youngest so the youngest word match wins.
    // Only that youngest match may forward; if it does not cover every
    // requested byte, older matches are stale for those bytes anyway.
    always_comb begin : p_forward
        w_fwd_match = 1'b0;
        w_fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CNT_W'(i) < count_q) &&
                (addr_q[head_q + c_PTR_W'(i)][31:2] == cpu_addr[31:2])) begin
                w_fwd_match = 1'b1;
                w_fwd_idx   = head_q + c_PTR_W'(i);
            end
        end
        w_fwd_hit = w_load_req && w_fwd_match &&
                    ((be_q[w_fwd_idx] & cpu_byte_en) == cpu_byte_en);
    end

    always_comb begin : p_fsm
        state_d     = state_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = '0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        w_pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_addr    = addr_q[head_q];
                    mem_wdata   = wdata_q[head_q];
                    mem_byte_en = be_q[head_q];
                    mem_wen     = 1'b1;
                    state_d     = DRAIN;
                end else if (w_load_req && !w_fwd_hit) begin
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                mem_addr    = addr_q[head_q];
                mem_wdata   = wdata_q[head_q];
                mem_byte_en = be_q[head_q];
                mem_wen     = 1'b1;
                if (!mem_busy) begin
                    w_pop   = 1'b1;
                    state_d = (count_q > c_CNT_ONE) ? DRAIN : IDLE;
                end
            end
            LOAD: begin
                mem_addr    = cpu_addr;
                mem_byte_en = cpu_byte_en;
                mem_ren     = 1'b1;
                if (!mem_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : p_cpu_resp
        cpu_busy  = 1'b0;
        cpu_rdata = '0;
        if (cpu_wen) begin
            cpu_busy = w_full;
        end else if (w_fwd_hit) begin
            cpu_rdata = wdata_q[w_fwd_idx];
        end else if (state_q == LOAD) begin
            cpu_rdata = mem_rdata;
            cpu_busy  = cpu_ren && mem_busy;
        end else if (cpu_ren) begin
            // Miss or partial overlap: wait for older stores to drain.
            cpu_busy = 1'b1;
        end
    end

    always_comb begin : p_ptr_next
        head_d  = w_pop  ? head_q + c_PTR_ONE : head_q;
        tail_d  = w_push ? tail_q + c_PTR_ONE : tail_q;
        count_d = count_q;
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin : p_state
        if (RST) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by count/head alone.
    always_ff @(posedge CLK) begin : p_entries
        if (w_push) begin
            addr_q[tail_q]  <= cpu_addr;
            wdata_q[tail_q] <= cpu_wdata;
            be_q[tail_q]    <= cpu_byte_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_store_buffer
// Purpose  : Directed self-checking bench for dbus_store_buffer (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_store_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_byte_en;
    logic        cpu_ren, cpu_wen, cpu_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ren, mem_wen, mem_busy;
    logic        drained;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dbus_store_buffer #(.DEPTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_byte_en (cpu_byte_en),
        .cpu_ren     (cpu_ren),
        .cpu_wen     (cpu_wen),
        .cpu_rdata   (cpu_rdata),
        .cpu_busy    (cpu_busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_rdata   (mem_rdata),
        .mem_busy    (mem_busy),
        .drained     (drained)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_byte_en = '0;
        cpu_ren     = 1'b0;
        cpu_wen     = 1'b0;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_addr    = a;
        cpu_wdata   = d;
        cpu_byte_en = be;
        cpu_ren     = 1'b0;
        cpu_wen     = 1'b1;
    endtask

    task automatic cpu_load(input logic [31:0] a, input logic [3:0] be);
        cpu_addr    = a;
        cpu_wdata   = '0;
        cpu_byte_en = be;
        cpu_ren     = 1'b1;
        cpu_wen     = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        mem_busy  = 1'b0;
        mem_rdata = '0;
        cpu_idle();
        step();
        step();
        RST = 1'b0;
        #1;
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_drained", drained, 1);
        chk("rst_cpu_rdata", cpu_rdata, 0);

        // ---- single store drains straight through ----
        cpu_store(32'h1000, 32'hDEADBEEF, 4'hF);
        #1;
        chk("st1_busy", cpu_busy, 0);
        step();
        cpu_idle();
        #1;
        chk("st1_mem_wen", mem_wen, 1);
        chk("st1_mem_addr", mem_addr, 32'h1000);
        chk("st1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st1_mem_be", mem_byte_en, 4'hF);
        chk("st1_not_drained", drained, 0);
        step();
        chk("st1_drain_wen", mem_wen, 1);
        chk("st1_drain_addr", mem_addr, 32'h1000);
        step();
        chk("st1_done_wen", mem_wen, 0);
        chk("st1_done_drained", drained, 1);

        // ---- fill while memory busy, fifth store waits ----
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_store(32'h2000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
            #1;
            chk("fill_busy", cpu_busy, 0);
            step();
        end
        cpu_store(32'h2010, 32'hA000_0004, 4'hF);
        #1;
        chk("full_busy", cpu_busy, 1);
        step();
        chk("full_busy_hold", cpu_busy, 1);
        chk("full_head_addr", mem_addr, 32'h2000);
        mem_busy = 1'b0;
        #1;
        chk("full_pop_busy", cpu_busy, 1);
        chk("ord0_wen", mem_wen, 1);
        chk("ord0_addr", mem_addr, 32'h2000);
        step();
        chk("fifth_accept", cpu_busy, 0);
        chk("ord1_addr", mem_addr, 32'h2004);
        step();
        cpu_idle();
        #1;
        chk("ord2_addr", mem_addr, 32'h2008);
        step();
        chk("ord3_addr", mem_addr, 32'h200C);
        step();
        chk("ord4_addr", mem_addr, 32'h2010);
        chk("ord4_wdata", mem_wdata, 32'hA000_0004);
        step();
        chk("fill_drained", drained, 1);
        chk("fill_wen_off", mem_wen, 0);

        // ---- forwarding ----
        mem_busy = 1'b1;
        cpu_store(32'h3000, 32'h11223344, 4'hF);
        step();
        cpu_load(32'h3002, 4'hC);
        #1;
        chk("fwd_busy", cpu_busy, 0);
        chk("fwd_rdata", cpu_rdata, 32'h11223344);
        chk("fwd_no_ren", mem_ren, 0);
        step();
        chk("fwd_drain_busy", cpu_busy, 0);
        chk("fwd_drain_rdata", cpu_rdata, 32'h11223344);
        chk("fwd_drain_no_ren", mem_ren, 0);
        cpu_store(32'h3000, 32'h55667788, 4'h3);
        #1;
        chk("fwd_st2_busy", cpu_busy, 0);
        step();
        cpu_load(32'h3000, 4'h1);
        #1;
        chk("young_busy", cpu_busy, 0);
        chk("young_rdata", cpu_rdata, 32'h55667788);
        cpu_load(32'h3000, 4'hC);
        #1;
        chk("young_partial_busy", cpu_busy, 1);
        chk("young_partial_rdata", cpu_rdata, 0);
        cpu_load(32'h4000, 4'hF);
        #1;
        chk("miss_busy", cpu_busy, 1);
        chk("miss_no_ren", mem_ren, 0);
        cpu_idle();
        mem_busy = 1'b0;
        step();
        step();
        chk("fwd_drained", drained, 1);

        // ---- partial overlap waits, then reads memory ----
        mem_busy = 1'b1;
        cpu_store(32'h3000, 32'hAABBCCDD, 4'h1);
        step();
        cpu_load(32'h3000, 4'hF);
        #1;
        chk("part_busy0", cpu_busy, 1);
        chk("part_no_ren0", mem_ren, 0);
        step();
        chk("part_busy1", cpu_busy, 1);
        chk("part_no_ren1", mem_ren, 0);
        mem_busy  = 1'b0;
        mem_rdata = 32'h12345678;
        step();
        chk("part_wait_busy", cpu_busy, 1);
        chk("part_wait_drained", drained, 1);
        chk("part_wait_no_ren", mem_ren, 0);
        mem_busy = 1'b1;
        step();
        chk("load_ren", mem_ren, 1);
        chk("load_wen", mem_wen, 0);
        chk("load_addr", mem_addr, 32'h3000);
        chk("load_be", mem_byte_en, 4'hF);
        chk("load_busy", cpu_busy, 1);
        mem_busy = 1'b0;
        #1;
        chk("load_done_busy", cpu_busy, 0);
        chk("load_rdata", cpu_rdata, 32'h12345678);
        step();
        cpu_idle();
        #1;
        chk("load_exit_ren", mem_ren, 0);
        chk("load_exit_wen", mem_wen, 0);
        chk("load_exit_rdata", cpu_rdata, 0);

        // ---- reset during drain discards everything ----
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_store(32'h5000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
            step();
        end
        cpu_idle();
        #1;
        chk("rstd_pre_wen", mem_wen, 1);
        chk("rstd_pre_drained", drained, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        chk("rstd_wen", mem_wen, 0);
        chk("rstd_drained", drained, 1);
        chk("rstd_busy", cpu_busy, 0);
        mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstd_quiet_wen", mem_wen, 0);
            chk("rstd_quiet_ren", mem_ren, 0);
        end

        // ---- full buffer with simultaneous pop refuses the store ----
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_store(32'h6000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF);
            step();
        end
        cpu_store(32'h6010, 32'hC000_0004, 4'hF);
        mem_busy = 1'b0;
        #1;
        chk("popfull_refuse", cpu_busy, 1);
        step();
        chk("popfull_accept", cpu_busy, 0);
        mem_busy = 1'b1;
        step();
        cpu_store(32'h6014, 32'hC000_0005, 4'hF);
        #1;
        chk("popfull_full_again", cpu_busy, 1);
        cpu_idle();
        mem_busy = 1'b0;
        #1;
        chk("pf_ord1", mem_addr, 32'h6004);
        step();
        chk("pf_ord2", mem_addr, 32'h6008);
        step();
        chk("pf_ord3", mem_addr, 32'h600C);
        step();
        chk("pf_ord4", mem_addr, 32'h6010);
        chk("pf_ord4_data", mem_wdata, 32'hC000_0004);
        step();
        chk("pf_drained", drained, 1);
        chk("pf_wen_off", mem_wen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
